// File: rtl/sum_accumulator_pkg.sv
// Shared types and default widths for the sum accumulator.
package sum_accumulator_pkg;

    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned ACC_W_DEF   = 40;
    localparam int unsigned COUNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/sum_accumulator_if.sv
// Job control, sample input and total output handshakes of the sum accumulator.
interface sum_accumulator_if
    import sum_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned COUNT_W = COUNT_W_DEF
);

    logic               Start;
    logic [COUNT_W-1:0] Len;
    logic               In_valid;
    logic               In_ready;
    logic [WIDTH-1:0]   Sum;
    logic               Cout;
    logic               Acc_valid;
    logic               Acc_ready;
    logic [ACC_W-1:0]   Acc;
    logic               Overflow;
    logic               Busy;

    modport master (
        output Start, Len, In_valid, Sum, Cout, Acc_ready,
        input  In_ready, Acc_valid, Acc, Overflow, Busy
    );

    modport slave (
        input  Start, Len, In_valid, Sum, Cout, Acc_ready,
        output In_ready, Acc_valid, Acc, Overflow, Busy
    );

endinterface

// File: rtl/sum_accumulator.sv
// Accumulates a programmed number of {Cout, Sum} adder results into a wide total
// and hands the total off over a valid/ready handshake.
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned COUNT_W = COUNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    sum_accumulator_if.slave bus
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               overflow_q, overflow_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               in_ready_q, in_ready_d;
    logic               acc_valid_q, acc_valid_d;
    logic               busy_q, busy_d;

    logic [ACC_W-1:0]   sample;
    logic [ACC_W:0]     acc_sum;

    always_comb begin
        sample  = ACC_W'({bus.Cout, bus.Sum});
        acc_sum = {1'b0, acc_q} + {1'b0, sample};
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        overflow_d = overflow_q;
        count_d    = count_q;

        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    acc_d      = '0;
                    overflow_d = 1'b0;
                    if (bus.Len != '0) begin
                        count_d = bus.Len;
                        state_d = ACCUM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACCUM: begin
                if (bus.In_valid && in_ready_q) begin
                    acc_d   = acc_sum[ACC_W-1:0];
                    count_d = count_q - COUNT_W'(1);
                    if (acc_sum[ACC_W]) begin
                        overflow_d = 1'b1;
                    end
                    if (count_q == COUNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (acc_valid_q && bus.Acc_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are decoded from the next state so they are flops,
        // keeping In_valid/Acc_ready off any combinational path to them.
        in_ready_d  = (state_d == ACCUM);
        acc_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            overflow_q  <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            acc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            acc_valid_q <= acc_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.In_ready  = in_ready_q;
    assign bus.Acc_valid = acc_valid_q;
    assign bus.Acc       = acc_q;
    assign bus.Overflow  = overflow_q;
    assign bus.Busy      = busy_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed and randomized jobs for sum_accumulator, checked against a running
// arithmetic model of the expected total and overflow flag.
module tb_sum_accumulator;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned ACC_W   = 40;
    localparam int unsigned COUNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sum_accumulator_if #(.WIDTH(WIDTH), .ACC_W(ACC_W), .COUNT_W(COUNT_W)) bus ();

    sum_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .COUNT_W(COUNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [WIDTH:0] samp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".in_ready"},  64'(bus.In_ready),  64'd0);
        check({tag, ".acc_valid"}, 64'(bus.Acc_valid), 64'd0);
        check({tag, ".busy"},      64'(bus.Busy),      64'd0);
    endtask

    task automatic fill_random(input int n);
        logic [WIDTH:0] s;
        samp_q.delete();
        for (int i = 0; i < n; i++) begin
            s = {1'($urandom_range(0, 1)), 32'($urandom)};
            samp_q.push_back(s);
        end
    endtask

    // gap >= 0: that many idle cycles before every sample but the first;
    // gap < 0: random 0..2 idle cycles before each sample.
    task automatic do_job(input string name, input int len, input int gap,
                          input int ready_delay, input int busy_start_idx,
                          input bit handoff_start);
        longint unsigned exp_acc;
        longint unsigned wide;
        logic            exp_ovf;
        int              ngap;

        exp_acc = 0;
        exp_ovf = 1'b0;
        for (int i = 0; i < len; i++) begin
            wide = exp_acc + longint'(samp_q[i]);
            if ((wide >> ACC_W) != 0) exp_ovf = 1'b1;
            exp_acc = wide % (64'd1 << ACC_W);
        end

        @(negedge clk);
        check_idle({name, ".pre"});
        bus.Start     = 1'b1;
        bus.Len       = COUNT_W'(len);
        bus.Acc_ready = (ready_delay == 0);

        @(negedge clk);
        bus.Start = 1'b0;
        check({name, ".cleared_acc"}, 64'(bus.Acc),      64'd0);
        check({name, ".cleared_ovf"}, 64'(bus.Overflow), 64'd0);
        check({name, ".busy"},        64'(bus.Busy),     64'd1);

        if (len != 0) begin
            for (int i = 0; i < len; i++) begin
                ngap = (gap < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap);
                for (int g = 0; g < ngap; g++) begin
                    check({name, ".gap_in_ready"}, 64'(bus.In_ready), 64'd1);
                    bus.Start    = 1'b0;
                    bus.In_valid = 1'b0;
                    {bus.Cout, bus.Sum} = 33'($urandom);
                    @(negedge clk);
                end
                check({name, ".in_ready"},  64'(bus.In_ready),  64'd1);
                check({name, ".no_valid"},  64'(bus.Acc_valid), 64'd0);
                bus.Start    = (i == busy_start_idx);
                bus.Len      = COUNT_W'(1);
                bus.In_valid = 1'b1;
                {bus.Cout, bus.Sum} = samp_q[i];
                @(negedge clk);
            end
            bus.Start    = 1'b0;
            bus.In_valid = 1'b0;
        end

        check({name, ".acc_valid"}, 64'(bus.Acc_valid), 64'd1);
        check({name, ".acc"},       64'(bus.Acc),       exp_acc);
        check({name, ".overflow"},  64'(bus.Overflow),  64'(exp_ovf));
        check({name, ".done_in_ready"}, 64'(bus.In_ready), 64'd0);

        for (int r = 0; r < ready_delay; r++) begin
            @(negedge clk);
            check({name, ".hold_valid"}, 64'(bus.Acc_valid), 64'd1);
            check({name, ".hold_acc"},   64'(bus.Acc),       exp_acc);
        end
        bus.Acc_ready = 1'b1;
        bus.Start     = handoff_start;
        bus.Len       = COUNT_W'(5);

        @(negedge clk);
        bus.Start = 1'b0;
        check_idle({name, ".post"});
        check({name, ".keep_acc"}, 64'(bus.Acc),      exp_acc);
        check({name, ".keep_ovf"}, 64'(bus.Overflow), 64'(exp_ovf));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Start     = 1'b0;
        bus.Len       = '0;
        bus.In_valid  = 1'b0;
        bus.Sum       = '0;
        bus.Cout      = 1'b0;
        bus.Acc_ready = 1'b1;

        @(negedge clk);
        check_idle("reset");
        check("reset.acc", 64'(bus.Acc),      64'd0);
        check("reset.ovf", 64'(bus.Overflow), 64'd0);
        rst = 1'b0;

        samp_q = '{33'd46, 33'd68, 33'd168};
        do_job("basic", 3, 0, 0, -1, 1'b0);

        samp_q = '{33'd90, {1'b1, 32'd0}};
        do_job("backpressure", 2, 3, 4, -1, 1'b0);

        samp_q.delete();
        for (int i = 0; i < 255; i++) samp_q.push_back({1'b1, 32'hFFFF_FFFF});
        do_job("overflow", 255, 0, 0, -1, 1'b0);

        samp_q.delete();
        do_job("len0", 0, 0, 1, -1, 1'b0);

        fill_random(4);
        do_job("busy_start", 4, 0, 2, 2, 1'b1);

        // Reset in the middle of a Len=4 job after two samples.
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Len   = COUNT_W'(4);
        @(negedge clk);
        bus.Start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.In_valid = 1'b1;
            {bus.Cout, bus.Sum} = 33'($urandom);
            @(negedge clk);
        end
        bus.In_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_idle("midrst");
        check("midrst.acc", 64'(bus.Acc),      64'd0);
        check("midrst.ovf", 64'(bus.Overflow), 64'd0);
        rst = 1'b0;

        fill_random(5);
        do_job("after_rst", 5, 0, 0, -1, 1'b0);

        for (int j = 0; j < 6; j++) begin
            int len;
            len = int'($urandom_range(1, 20));
            fill_random(len);
            do_job("random", len, -1, int'($urandom_range(0, 3)), -1, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream consumer of the cascaded 32-bit adder. Takes its {Cout, Sum} results one at a time over a valid/ready handshake.
- Accumulates a programmed number of results into a wide register and presents the total over a second valid/ready handshake.
- Used for multi-operand summation built from repeated two-operand adds.

Parameters:
WIDTH, 32, width of adder Sum input
ACC_W, 40, accumulator width; must be >= WIDTH+1
COUNT_W, 8, width of sample-count field (max 2^COUNT_W-1 samples per job)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
Start  input  1  job start pulse; sampled only in IDLE
Len  input  COUNT_W  number of adder results to accumulate; sampled with Start
In_valid  input  1  Sum/Cout valid from adder stage
In_ready  output  1  accumulator accepts a sample this cycle
Sum  input  WIDTH  adder sum
Cout  input  1  adder carry-out
Acc_valid  output  1  total valid
Acc_ready  input  1  consumer accepts total
Acc  output  ACC_W  accumulated total
Overflow  output  1  sticky: total exceeded 2^ACC_W-1 during this job
Busy  output  1  high in ACCUM or DONE

Behaviour:
- Clock and reset: single clock, clk. Reset rst is synchronous and active-high; it overrides everything, including mid-job.
- Reset values: state=IDLE, Acc=0, Overflow=0, count=0, In_ready=0, Acc_valid=0, Busy=0.
- Sample value: zero-extended {Cout, Sum} (WIDTH+1 bits) to ACC_W.
- Accumulator arithmetic: sum modulo 2^ACC_W. The carry out of bit ACC_W-1 sets Overflow; Overflow stays set until the next accepted Start or rst.
- State machine (registered outputs, In_ready/Acc_valid decoded from state):
  - IDLE: In_ready=0, Acc_valid=0.
    - Start=1 and Len!=0: clear Acc and Overflow, count<=Len, go to ACCUM.
    - Start=1 and Len==0: clear Acc and Overflow, go directly to DONE (Acc=0).
    - Start=0: stay in IDLE.
  - ACCUM: In_ready=1.
    - On In_valid&In_ready: Acc<=Acc+sample, count<=count-1.
    - If that transfer occurs with count==1, go to DONE next cycle.
    - In_valid low: hold; no timeout.
  - DONE: Acc_valid=1, Acc stable.
    - On Acc_valid&Acc_ready: go to IDLE; Acc and Overflow keep their values.
- Latency: Acc_valid rises on the cycle after the final accepted sample. With Acc_ready tied high, it is a one-cycle pulse.
- Start while Busy: ignored, with no side effects. Start on the same cycle DONE hands off: ignored (state is not yet IDLE).
- Sum/Cout are don't-care when the transfer is not taken.
- Throughput: one sample per cycle in ACCUM. There is no combinational path from In_valid to In_ready, or from Acc_ready to Acc_valid.

Decomposition:
- Shared package: state enum (IDLE, ACCUM, DONE) and default widths WIDTH/ACC_W/COUNT_W.
- No sub-module needed. The adder itself stays the existing cascaded adder; this block is flat FSM, counter and accumulator.

Test Plan:
- Basic job: Start with Len=3, then back-to-back samples {0,46}, {0,68}, {0,168} with Acc_ready=1. Required: Acc=282, Overflow=0, Acc_valid pulses 1 cycle after the 3rd transfer.
- Backpressure/gaps: Len=2, In_valid low for 3 cycles between samples {0,90} and {1,0}. Required: In_ready stays 1, Acc=0x1_0000005A. Hold Acc_ready=0 for 4 cycles; Acc_valid and Acc stay stable until the handshake, then return to IDLE.
- Overflow (defaults): Len=255, each sample {1,0xFFFFFFFF}. Required: Acc=0x0FDFFFFFF01, Overflow=1. Next Start clears Overflow to 0.
- Len=0: Start with Len=0. Required: DONE next cycle, Acc_valid=1, Acc=0, In_ready never asserts.
- Start while busy and reset mid-job: Len=4, feed 2 samples, pulse Start (Len=1). Required: ignored, job completes after 4 samples. Repeat with rst=1 after 2 samples; next cycle all outputs equal reset values and the next job starts clean.
